// File: rtl/conv_args_fetch_ctrl.sv
// Per-group argument fetch controller: issues word reads for NUM_STREAMS packed argument
// buffers and reports register-file slices. Optional macro: CONV_ARGS_AUTO_WRAP_EN.
module conv_args_fetch_ctrl #(
    parameter int unsigned              NUM_STREAMS   = 3,
    parameter int unsigned              ADR_W         = 16,
    parameter int unsigned              ROW_BASE_LOG2 = 6,
    parameter logic [4*NUM_STREAMS-1:0] WORD_LOG2     = 12'h656,
    parameter int unsigned              REG_W         = 9
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_load,
    input  logic [1:0]                   mode_init,
    input  logic [15:0]                  of_init,
    input  logic [NUM_STREAMS*ADR_W-1:0] base_adr_init,
    input  logic                         refresh_valid,
    output logic                         refresh_ready,
    output logic [NUM_STREAMS-1:0]       buf_rd,
    output logic [NUM_STREAMS*ADR_W-1:0] buf_adr_rd,
    output logic [NUM_STREAMS*REG_W-1:0] reg_start,
    output logic [NUM_STREAMS*REG_W-1:0] reg_size,
    output logic [NUM_STREAMS*REG_W-1:0] word_ofs,
    output logic                         group_done,
    output logic                         layer_done
);

    typedef enum logic [1:0] {ST_UNCFG, ST_IDLE, ST_BUSY, ST_FINISHED} state_t;

    state_t                         state_q;
    logic [1:0]                     mode_q;
    logic [15:0]                    of_q;
    logic [NUM_STREAMS*ADR_W-1:0]   base_q;
    logic [15:0]                    a_q;
    logic [15:0]                    gs_q;
    logic [15:0]                    ge_q;
    logic [NUM_STREAMS-1:0][15:0]   ai_q;

    logic                           accept_s;
    logic [1:0]                     mode_eff_s;
    logic [16:0]                    grp_end_s;
    logic [15:0]                    ge_new_s;
    logic [15:0]                    gs_src_s;
    logic [15:0]                    ge_src_s;
    logic                           issue_s;
    logic                           busy_end_s;
    logic [NUM_STREAMS-1:0]         act_s;
    logic [NUM_STREAMS-1:0][15:0]   src_s;
    logic [NUM_STREAMS-1:0][16:0]   wsize_s;
    logic [NUM_STREAMS-1:0][15:0]   ofs_s;
    logic [NUM_STREAMS-1:0][16:0]   rem_s;
    logic [NUM_STREAMS-1:0][16:0]   wrem_s;
    logic [NUM_STREAMS-1:0][16:0]   size_s;
    logic [NUM_STREAMS-1:0][ADR_W-1:0] adr_s;
    logic [NUM_STREAMS-1:0][15:0]   start_s;
    logic [NUM_STREAMS-1:0][15:0]   nxt_s;

    // Group bounds and the next read of every stream; on the accept cycle streams start from a_q.
    always_comb begin
        accept_s   = refresh_valid & refresh_ready & ~cfg_load;
        mode_eff_s = (mode_q == 2'd3) ? 2'd2 : mode_q;
        grp_end_s  = {1'b0, a_q} + (17'd1 << (ROW_BASE_LOG2 + 32'(mode_eff_s)));
        if (grp_end_s > {1'b0, of_q}) begin
            ge_new_s = of_q;
        end else begin
            ge_new_s = grp_end_s[15:0];
        end
        gs_src_s = accept_s ? a_q : gs_q;
        ge_src_s = accept_s ? ge_new_s : ge_q;
        act_s    = '0;
        src_s    = '0;
        wsize_s  = '0;
        ofs_s    = '0;
        rem_s    = '0;
        wrem_s   = '0;
        size_s   = '0;
        adr_s    = '0;
        start_s  = '0;
        nxt_s    = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            src_s[i]   = accept_s ? a_q : ai_q[i];
            wsize_s[i] = 17'd1 << WORD_LOG2[4*i +: 4];
            ofs_s[i]   = src_s[i] & (wsize_s[i][15:0] - 16'd1);
            rem_s[i]   = {1'b0, ge_src_s} - {1'b0, src_s[i]};
            wrem_s[i]  = wsize_s[i] - {1'b0, ofs_s[i]};
            size_s[i]  = (rem_s[i] < wrem_s[i]) ? rem_s[i] : wrem_s[i];
            adr_s[i]   = base_q[i*ADR_W +: ADR_W] + ADR_W'(src_s[i] >> WORD_LOG2[4*i +: 4]);
            start_s[i] = src_s[i] - gs_src_s;
            nxt_s[i]   = src_s[i] + size_s[i][15:0];
            act_s[i]   = (src_s[i] != ge_src_s);
        end
        issue_s    = ((state_q == ST_IDLE) & accept_s) | ((state_q == ST_BUSY) & (|act_s));
        busy_end_s = (state_q == ST_BUSY) & ~(|act_s);
    end

    // Control FSM: configuration, group pointer, handshake and completion flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_UNCFG;
            mode_q        <= 2'd0;
            of_q          <= 16'd0;
            base_q        <= '0;
            a_q           <= 16'd0;
            gs_q          <= 16'd0;
            ge_q          <= 16'd0;
            refresh_ready <= 1'b0;
            group_done    <= 1'b0;
            layer_done    <= 1'b0;
        end else if (cfg_load) begin
            mode_q     <= mode_init;
            of_q       <= of_init;
            base_q     <= base_adr_init;
            a_q        <= 16'd0;
            gs_q       <= 16'd0;
            ge_q       <= 16'd0;
            group_done <= 1'b0;
            if (of_init == 16'd0) begin
                state_q       <= ST_FINISHED;
                refresh_ready <= 1'b0;
                layer_done    <= 1'b1;
            end else begin
                state_q       <= ST_IDLE;
                refresh_ready <= 1'b1;
                layer_done    <= 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    group_done <= 1'b0;
                    layer_done <= 1'b0;
                    if (accept_s) begin
                        gs_q          <= a_q;
                        ge_q          <= ge_new_s;
                        refresh_ready <= 1'b0;
                        state_q       <= ST_BUSY;
                    end else begin
                        refresh_ready <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (busy_end_s) begin
                        group_done <= 1'b1;
                        if (ge_q == of_q) begin
`ifdef CONV_ARGS_AUTO_WRAP_EN
                            a_q           <= 16'd0;
                            layer_done    <= 1'b1;
                            refresh_ready <= 1'b1;
                            state_q       <= ST_IDLE;
`else
                            a_q           <= ge_q;
                            layer_done    <= 1'b1;
                            refresh_ready <= 1'b0;
                            state_q       <= ST_FINISHED;
`endif
                        end else begin
                            a_q           <= ge_q;
                            refresh_ready <= 1'b1;
                            state_q       <= ST_IDLE;
                        end
                    end else begin
                        group_done <= 1'b0;
                    end
                end
                ST_FINISHED: begin
                    group_done    <= 1'b0;
                    refresh_ready <= 1'b0;
                end
                default: begin
                    group_done    <= 1'b0;
                    refresh_ready <= 1'b0;
                    layer_done    <= 1'b0;
                end
            endcase
        end
    end

    // Per-stream read issue; slice fields hold their last value while the strobe is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_rd     <= '0;
            buf_adr_rd <= '0;
            reg_start  <= '0;
            reg_size   <= '0;
            word_ofs   <= '0;
            ai_q       <= '0;
        end else if (cfg_load) begin
            buf_rd <= '0;
            ai_q   <= '0;
        end else if (issue_s) begin
            buf_rd <= act_s;
            for (int i = 0; i < NUM_STREAMS; i++) begin
                if (act_s[i]) begin
                    buf_adr_rd[i*ADR_W +: ADR_W] <= adr_s[i];
                    reg_start[i*REG_W +: REG_W]  <= REG_W'(start_s[i]);
                    reg_size[i*REG_W +: REG_W]   <= REG_W'(size_s[i]);
                    word_ofs[i*REG_W +: REG_W]   <= REG_W'(ofs_s[i]);
                    ai_q[i]                      <= nxt_s[i];
                end else begin
                    ai_q[i] <= ai_q[i];
                end
            end
        end else begin
            buf_rd <= '0;
        end
    end

endmodule

// File: tb/tb_conv_args_fetch_ctrl.sv
// Directed bench for conv_args_fetch_ctrl; a second instance uses a 128-arg word on stream 0.
module tb_conv_args_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_load;
    logic [1:0]  mode_init;
    logic [15:0] of_init;
    logic [47:0] base_adr_init;
    logic        refresh_valid;

    logic        rr, gd, ld;
    logic [2:0]  rd;
    logic [47:0] adr;
    logic [26:0] st, sz, wo;

    logic        rr2, gd2, ld2;
    logic [2:0]  rd2;
    logic [47:0] adr2;
    logic [26:0] st2, sz2, wo2;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    conv_args_fetch_ctrl dut (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .mode_init(mode_init),
        .of_init(of_init), .base_adr_init(base_adr_init), .refresh_valid(refresh_valid),
        .refresh_ready(rr), .buf_rd(rd), .buf_adr_rd(adr), .reg_start(st),
        .reg_size(sz), .word_ofs(wo), .group_done(gd), .layer_done(ld)
    );

    conv_args_fetch_ctrl #(.WORD_LOG2(12'h657)) dut2 (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .mode_init(mode_init),
        .of_init(of_init), .base_adr_init(base_adr_init), .refresh_valid(refresh_valid),
        .refresh_ready(rr2), .buf_rd(rd2), .buf_adr_rd(adr2), .reg_start(st2),
        .reg_size(sz2), .word_ofs(wo2), .group_done(gd2), .layer_done(ld2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check one stream of the main instance: address, start, size, word offset.
    task automatic chk_s(input string tag, input int s, input logic [15:0] ea,
                         input logic [8:0] es, input logic [8:0] ez, input logic [8:0] eo);
        chk({tag, "_adr"},   32'(adr[s*16 +: 16]), 32'(ea));
        chk({tag, "_start"}, 32'(st[s*9 +: 9]),    32'(es));
        chk({tag, "_size"},  32'(sz[s*9 +: 9]),    32'(ez));
        chk({tag, "_ofs"},   32'(wo[s*9 +: 9]),    32'(eo));
    endtask

    task automatic do_cfg(input logic [1:0] m, input logic [15:0] of, input logic [47:0] base);
        mode_init     = m;
        of_init       = of;
        base_adr_init = base;
        cfg_load      = 1'b1;
        tick();
        cfg_load      = 1'b0;
    endtask

    task automatic accept();
        refresh_valid = 1'b1;
        tick();
        refresh_valid = 1'b0;
    endtask

    task automatic wait_gd(output int cnt);
        cnt = 0;
        while (gd !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("wait_group_done", 32'(gd), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cfg_load = 1'b0; mode_init = 2'd0; of_init = 16'd0;
        base_adr_init = 48'd0; refresh_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_ready", 32'(rr), 32'd0);
        chk("rst_rd",    32'(rd), 32'd0);
        chk("rst_ld",    32'(ld), 32'd0);
        chk("rst_gd",    32'(gd), 32'd0);
        refresh_valid = 1'b1; tick(); tick(); refresh_valid = 1'b0;
        chk("uncfg_rd",  32'(rd), 32'd0);

        // Mode 0, 129 args, all bases zero
        do_cfg(2'd0, 16'd129, 48'd0);
        chk("t1_ready", 32'(rr), 32'd1);
        accept();
        chk("t1g0_rd", 32'(rd), 32'd7);
        chk("t1g0_ready", 32'(rr), 32'd0);
        chk_s("t1g0_s0", 0, 16'd0, 9'd0, 9'd64, 9'd0);
        chk_s("t1g0_s1a", 1, 16'd0, 9'd0, 9'd32, 9'd0);
        chk_s("t1g0_s2", 2, 16'd0, 9'd0, 9'd64, 9'd0);
        tick();
        chk("t1g0_rd2", 32'(rd), 32'd2);
        chk_s("t1g0_s1b", 1, 16'd1, 9'd32, 9'd32, 9'd0);
        tick();
        chk("t1g0_rd3", 32'(rd), 32'd0);
        chk("t1g0_gd", 32'(gd), 32'd1);
        chk("t1g0_ready2", 32'(rr), 32'd1);
        accept();
        chk("t1g1_rd", 32'(rd), 32'd7);
        chk("t1g1_gd", 32'(gd), 32'd0);
        chk_s("t1g1_s0", 0, 16'd1, 9'd0, 9'd64, 9'd0);
        chk_s("t1g1_s1a", 1, 16'd2, 9'd0, 9'd32, 9'd0);
        tick();
        chk_s("t1g1_s1b", 1, 16'd3, 9'd32, 9'd32, 9'd0);
        tick();
        chk("t1g1_gd2", 32'(gd), 32'd1);
        chk("t1g1_ld", 32'(ld), 32'd0);
        accept();
        chk("t1g2_rd", 32'(rd), 32'd7);
        chk_s("t1g2_s0", 0, 16'd2, 9'd0, 9'd1, 9'd0);
        chk_s("t1g2_s1", 1, 16'd4, 9'd0, 9'd1, 9'd0);
        tick();
        chk("t1g2_rd2", 32'(rd), 32'd0);
        chk("t1g2_gd", 32'(gd), 32'd1);
        chk("t1g2_ld", 32'(ld), 32'd1);
        chk("t1g2_ready", 32'(rr), 32'd0);
        refresh_valid = 1'b1; tick(); tick(); refresh_valid = 1'b0;
        chk("t1_4th_rd", 32'(rd), 32'd0);
        chk("t1_4th_ready", 32'(rr), 32'd0);
        chk("t1_ld_sticky", 32'(ld), 32'd1);
        chk("t1_gd_pulse", 32'(gd), 32'd0);

        // Mode 1, 257 args, stream 1 base 0x100
        do_cfg(2'd1, 16'd257, {16'd0, 16'h0100, 16'd0});
        chk("t2_ld_clr", 32'(ld), 32'd0);
        accept();
        chk("t2g0_rd", 32'(rd), 32'd7);
        chk_s("t2g0_s0a", 0, 16'd0, 9'd0, 9'd64, 9'd0);
        chk_s("t2g0_s1a", 1, 16'h0100, 9'd0, 9'd32, 9'd0);
        tick();
        chk("t2g0_rd2", 32'(rd), 32'd7);
        chk_s("t2g0_s0b", 0, 16'd1, 9'd64, 9'd64, 9'd0);
        chk_s("t2g0_s1b", 1, 16'h0101, 9'd32, 9'd32, 9'd0);
        tick();
        chk("t2g0_rd3", 32'(rd), 32'd2);
        chk_s("t2g0_s1c", 1, 16'h0102, 9'd64, 9'd32, 9'd0);
        tick();
        chk_s("t2g0_s1d", 1, 16'h0103, 9'd96, 9'd32, 9'd0);
        tick();
        chk("t2g0_gd", 32'(gd), 32'd1);
        accept();
        wait_gd(n);
        chk("t2g1_len", 32'(n), 32'd4);
        accept();
        chk("t2g2_rd", 32'(rd), 32'd7);
        chk_s("t2g2_s0", 0, 16'd4, 9'd0, 9'd1, 9'd0);
        chk_s("t2g2_s1", 1, 16'h0108, 9'd0, 9'd1, 9'd0);
        tick();
        chk("t2g2_gd", 32'(gd), 32'd1);
        chk("t2g2_ld", 32'(ld), 32'd1);

        // 128-arg words on stream 0 of the second instance, 128 args
        do_cfg(2'd0, 16'd128, 48'd0);
        accept();
        chk("t3g0_rd", 32'(rd2[0]), 32'd1);
        chk("t3g0_adr", 32'(adr2[15:0]), 32'd0);
        chk("t3g0_ofs", 32'(wo2[8:0]), 32'd0);
        chk("t3g0_size", 32'(sz2[8:0]), 32'd64);
        wait_gd(n);
        chk("t3g0_gd2", 32'(gd2), 32'd1);
        accept();
        chk("t3g1_rd", 32'(rd2[0]), 32'd1);
        chk("t3g1_adr", 32'(adr2[15:0]), 32'd0);
        chk("t3g1_ofs", 32'(wo2[8:0]), 32'd64);
        chk("t3g1_start", 32'(st2[8:0]), 32'd0);
        chk("t3g1_size", 32'(sz2[8:0]), 32'd64);

        // cfg_load aborts group 1 mid-flight and beats a same-cycle refresh
        do_cfg(2'd0, 16'd129, 48'd0);
        accept();
        wait_gd(n);
        accept();
        chk_s("t4g1_s0", 0, 16'd1, 9'd0, 9'd64, 9'd0);
        do_cfg(2'd0, 16'd129, 48'd0);
        chk("t4_abort_rd", 32'(rd), 32'd0);
        chk("t4_abort_ready", 32'(rr), 32'd1);
        chk("t4_abort_gd", 32'(gd), 32'd0);
        refresh_valid = 1'b1;
        do_cfg(2'd0, 16'd129, 48'd0);
        refresh_valid = 1'b0;
        chk("t4_beat_rd", 32'(rd), 32'd0);
        chk("t4_beat_ready", 32'(rr), 32'd1);
        accept();
        chk("t4_restart_rd", 32'(rd), 32'd7);
        chk_s("t4_restart_s0", 0, 16'd0, 9'd0, 9'd64, 9'd0);
        chk_s("t4_restart_s1", 1, 16'd0, 9'd0, 9'd32, 9'd0);

        // Empty layer
        do_cfg(2'd0, 16'd0, 48'd0);
        chk("t5_ld", 32'(ld), 32'd1);
        chk("t5_ready", 32'(rr), 32'd0);
        refresh_valid = 1'b1; tick(); tick(); refresh_valid = 1'b0;
        chk("t5_rd", 32'(rd), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_args_fetch_ctrl.md
Name: conv_args_fetch_ctrl

Overview:
Parametrised successor to the single-mode conv argument controller. Generates per-group read addresses for NUM_STREAMS argument buffers (bias / tail / rank by default), each with its own words-per-entry packing, and supplies the destination slice (start, size) and source word offset for the argument register file. Supports three row-group modes, partial/unaligned words, and a valid/ready refresh handshake with group and layer completion flags. Sits between the conv layer sequencer and the e_scale argument buffers.

Parameters:
NUM_STREAMS, 3, number of independent argument streams
ADR_W, 16, buffer address width per stream
ROW_BASE_LOG2, 6, log2 of args per group in mode 0 (64)
WORD_LOG2, 12'h656, packed 4 bits per stream: log2 args per buffer word (s0=6, s1=5, s2=6); stream i at [4i+3:4i]
REG_W, 9, width of reg_start/reg_size/word_ofs fields

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
cfg_load  in  1  one-cycle pulse: latch config, clear progress
mode_init  in  2  group mode 0..2; rows per group R = 1<<(ROW_BASE_LOG2+mode); 3 treated as 2
of_init  in  16  total output-filter args in layer
base_adr_init  in  NUM_STREAMS*ADR_W  per-stream layer base address
refresh_valid  in  1  request next group
refresh_ready  out  1  controller idle and layer not finished
buf_rd  out  NUM_STREAMS  per-stream read strobe
buf_adr_rd  out  NUM_STREAMS*ADR_W  read address, valid with buf_rd
reg_start  out  NUM_STREAMS*REG_W  destination offset in register file (0..R-1)
reg_size  out  NUM_STREAMS*REG_W  arg count this read (1..min(R,W))
word_ofs  out  NUM_STREAMS*REG_W  first arg index within the read word
group_done  out  1  one-cycle pulse: group fully issued
layer_done  out  1  all of_init args issued

Behaviour:
- Reset: all outputs 0 except refresh_ready=0; state IDLE_UNCFG. Config registers cleared.
- States: UNCFG -> (cfg_load) IDLE -> (refresh accept) BUSY -> (all streams reach group end) DONE (1 cycle) -> IDLE, or -> FINISHED if group end == of.
- cfg_load in any state: latch config, group pointer a=0, abort BUSY, buf_rd low next cycle; next state IDLE (FINISHED if of_init==0, layer_done=1 next cycle). cfg_load beats a same-cycle refresh_valid (not accepted).
- refresh_ready = 1 only in IDLE. Accept = refresh_valid & refresh_ready & ~cfg_load. Group range [gs, ge) with gs=a, ge=min(a+R, of).
- BUSY, per stream i independently, W=1<<WORD_LOG2[i], one read per cycle: ofs=a_i mod W; size=min(ge-a_i, W-ofs); buf_adr_rd=base_i+(a_i>>log2W) (ADR_W wrap); reg_start=a_i-gs; word_ofs=ofs; a_i+=size. Stream stops when a_i==ge; its buf_rd low thereafter.
- Outputs registered: first buf_rd in cycle after accept edge. Stream needs ceil-over-words reads; busy length = max over streams.
- group_done pulses cycle after last buf_rd of slowest stream; refresh_ready returns 1 that same cycle (unless finished). Earliest next accept that cycle.
- layer_done sets with group_done of final group, sticky until cfg_load/reset; refresh_valid then ignored, refresh_ready=0.
- Reset mid-BUSY: immediate return to reset values.

Optional Feature:
CONV_ARGS_AUTO_WRAP_EN: when defined, after final group a wraps to 0, layer_done is a one-cycle pulse coincident with group_done, and state returns to IDLE (layer re-streamed per spatial tile). Without it: layer_done sticky, FINISHED state as above.

Test Plan:
Defaults, mode0, of=129, bases 0, 3 refreshes -> g0: s0 adr0 start0 size64; s1 adr0/1 starts 0/32 size32; g1: s0 adr1, s1 adr2/3; g2: s0 adr2 size1, s1 adr4 size1, layer_done=1; 4th refresh ignored, refresh_ready=0.
mode1, of=257, s1 base 0x100 -> g0: s0 adr0,1 starts 0,64; s1 adr 0x100..0x103; g2 single arg size1 start0; layer_done after 3 groups.
WORD_LOG2 s0=7, mode0, of=128 -> g0 s0 adr0 ofs0 size64; g1 s0 adr0 ofs64 start0 size64.
cfg_load pulse during BUSY of g1 -> buf_rd low next cycle, refresh_ready=1, next group restarts at adr0.
of_init=0 then cfg_load -> layer_done=1, no buf_rd on refresh_valid.
With CONV_ARGS_AUTO_WRAP_EN, of=129 mode0, 4 refreshes -> layer_done pulse at g2, 4th group reissues s0 adr0 start0 size64.
